// File: rtl/cronometro_pkg.sv
// Shared types and constants for the race stopwatch timing core.
//   state_t  : control FSM state encoding (IDLE / RUNNING / FINISHED)
//   FIELD_W  : width of each displayed binary time field
//   CS_MAX   : last centisecond value before carry
//   SEC_MAX  : last second value before carry
package cronometro_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    FINISHED = 2'd2
  } state_t;

  localparam int FIELD_W = 7;
  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;

endpackage

// File: rtl/cronometro_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one
// asynchronous level input.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   async_in  : raw asynchronous level from the pin
//   level_out : synchronized level (two flops behind the pin)
//   rise_out  : one-cycle pulse on a 0->1 transition of level_out
module cronometro_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level_out,
  output logic rise_out
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_out = sync_q;
  assign rise_out  = sync_q & ~prev_q;

endmodule

// File: rtl/cronometro_core.sv
// Timing core of the race stopwatch. Conditions the start/finish/clear
// inputs, runs a minutes:seconds.centiseconds counter from a prescaled
// tick and holds the final time once the finish gate fires.
// Optional feature macro: CRONO_SPLIT_EN (split/lap display hold).
// Parameters:
//   CLK_HZ  : system clock frequency in Hz
//   TICK_HZ : counting resolution; CLK_HZ/TICK_HZ must be an integer >= 2
//   MAX_MIN : minutes value at which the count saturates
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start_sensor       : start gate level (asynchronous)
//   finish_sensor      : finish gate level (asynchronous)
//   btn_clear          : operator clear level (asynchronous)
//   split_btn          : split button level (CRONO_SPLIT_EN only)
//   centesimas         : centiseconds 0..99, binary
//   segundos           : seconds 0..59, binary
//   minutos            : minutes 0..MAX_MIN, binary
//   running, finished  : state decodes
//   split_active       : display is showing held split time (CRONO_SPLIT_EN only)
//   overflow           : sticky saturation flag
module cronometro_core
  import cronometro_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100,
  parameter int MAX_MIN = 99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_sensor,
  input  logic               finish_sensor,
  input  logic               btn_clear,
`ifdef CRONO_SPLIT_EN
  input  logic               split_btn,
  output logic               split_active,
`endif
  output logic [FIELD_W-1:0] centesimas,
  output logic [FIELD_W-1:0] segundos,
  output logic [FIELD_W-1:0] minutos,
  output logic               running,
  output logic               finished,
  output logic               overflow
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  function automatic logic at_limit(input logic [FIELD_W-1:0] cs,
                                    input logic [FIELD_W-1:0] sec,
                                    input logic [FIELD_W-1:0] mn);
    return (cs == FIELD_W'(CS_MAX)) && (sec == FIELD_W'(SEC_MAX)) &&
           (mn == FIELD_W'(MAX_MIN));
  endfunction

  // Input conditioning: sync + edge detect, event lands 3 clk after the pin
  logic start_rise, finish_rise, clr_lvl;
  logic start_lvl_unused, finish_lvl_unused, clr_rise_unused;

  cronometro_sync_edge u_start (
    .clk      (clk),
    .rst      (rst),
    .async_in (start_sensor),
    .level_out(start_lvl_unused),
    .rise_out (start_rise)
  );

  cronometro_sync_edge u_finish (
    .clk      (clk),
    .rst      (rst),
    .async_in (finish_sensor),
    .level_out(finish_lvl_unused),
    .rise_out (finish_rise)
  );

  // Clear acts on the synchronized level so holding the button keeps IDLE
  cronometro_sync_edge u_clear (
    .clk      (clk),
    .rst      (rst),
    .async_in (btn_clear),
    .level_out(clr_lvl),
    .rise_out (clr_rise_unused)
  );

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   presc_q;
  logic [FIELD_W-1:0] cs_q, sec_q, min_q;
  logic               ovf_q;
  logic               tick, sat, start_take;

  // Control: FSM next state and decoded outputs
  always_comb begin
    state_d    = state_q;
    running    = 1'b0;
    finished   = 1'b0;
    tick       = (state_q == RUNNING) && (presc_q == PRE_LAST);
    sat        = tick && at_limit(cs_q, sec_q, min_q);
    start_take = (state_q == IDLE) && start_rise;
    unique case (state_q)
      IDLE:     running  = 1'b0;
      RUNNING:  running  = 1'b1;
      FINISHED: finished = 1'b1;
      default:  running  = 1'b0;
    endcase
    if (clr_lvl) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (start_rise) state_d = RUNNING;
        RUNNING:  if (sat || finish_rise) state_d = FINISHED;
        FINISHED: state_d = FINISHED;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: prescaler and cascaded time fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cs_q    <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clr_lvl) begin
      presc_q <= '0;
      cs_q    <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (start_take) begin
      // Realign the prescaler so the first tick is exactly DIV clk later
      presc_q <= '0;
    end else if (state_q == RUNNING) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (sat) begin
          // Hold at the maximum time; the FSM moves to FINISHED this edge
          ovf_q <= 1'b1;
        end else if (cs_q == FIELD_W'(CS_MAX)) begin
          cs_q <= '0;
          if (sec_q == FIELD_W'(SEC_MAX)) begin
            sec_q <= '0;
            min_q <= min_q + 1'b1;
          end else begin
            sec_q <= sec_q + 1'b1;
          end
        end else begin
          cs_q <= cs_q + 1'b1;
        end
      end
    end
  end

  assign overflow = ovf_q;

`ifdef CRONO_SPLIT_EN
  logic               split_rise, split_lvl_unused;
  logic               split_q;
  logic [FIELD_W-1:0] hold_cs_q, hold_sec_q, hold_min_q;

  cronometro_sync_edge u_split (
    .clk      (clk),
    .rst      (rst),
    .async_in (split_btn),
    .level_out(split_lvl_unused),
    .rise_out (split_rise)
  );

  // Split hold: snapshot of the registered live time, toggled per event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_q    <= 1'b0;
      hold_cs_q  <= '0;
      hold_sec_q <= '0;
      hold_min_q <= '0;
    end else if (clr_lvl) begin
      split_q    <= 1'b0;
      hold_cs_q  <= '0;
      hold_sec_q <= '0;
      hold_min_q <= '0;
    end else if (state_q == RUNNING) begin
      if (sat || finish_rise) begin
        split_q <= 1'b0;
      end else if (split_rise) begin
        split_q <= ~split_q;
        if (!split_q) begin
          hold_cs_q  <= cs_q;
          hold_sec_q <= sec_q;
          hold_min_q <= min_q;
        end
      end
    end
  end

  assign split_active = split_q;
  assign centesimas   = split_q ? hold_cs_q  : cs_q;
  assign segundos     = split_q ? hold_sec_q : sec_q;
  assign minutos      = split_q ? hold_min_q : min_q;
`else
  assign centesimas = cs_q;
  assign segundos   = sec_q;
  assign minutos    = min_q;
`endif

endmodule

// File: tb/tb_cronometro_core.sv
// Bench for cronometro_core. Two instances share the same stimulus:
// dut_a uses DIV = 10 for latency/priority scenarios, dut_b uses DIV = 2 so
// rollover and saturation (MAX_MIN = 1) are reachable in a short run.
// A reference model expresses the time as elapsed ticks since the start
// event and pushes the expected outputs each edge; a monitor pops/compares.
module tb_cronometro_core;

  localparam int LIM = 1 * 6000 + 5999;  // 1:59.99 in ticks

  typedef struct {
    int cs;
    int sec;
    int mn;
    bit run;
    bit fin;
    bit ovf;
    bit spl;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_sensor = 1'b0, finish_sensor = 1'b0, btn_clear = 1'b0, split_btn = 1'b0;
  logic [6:0] a_cs, a_sec, a_min, b_cs, b_sec, b_min;
  logic a_run, a_fin, a_ovf, a_spl, b_run, b_fin, b_ovf, b_spl;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  cronometro_core #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_MIN(1)) dut_a (
    .clk(clk), .rst(rst), .start_sensor(start_sensor), .finish_sensor(finish_sensor),
    .btn_clear(btn_clear),
`ifdef CRONO_SPLIT_EN
    .split_btn(split_btn), .split_active(a_spl),
`endif
    .centesimas(a_cs), .segundos(a_sec), .minutos(a_min),
    .running(a_run), .finished(a_fin), .overflow(a_ovf)
  );

  cronometro_core #(.CLK_HZ(200), .TICK_HZ(100), .MAX_MIN(1)) dut_b (
    .clk(clk), .rst(rst), .start_sensor(start_sensor), .finish_sensor(finish_sensor),
    .btn_clear(btn_clear),
`ifdef CRONO_SPLIT_EN
    .split_btn(split_btn), .split_active(b_spl),
`endif
    .centesimas(b_cs), .segundos(b_sec), .minutos(b_min),
    .running(b_run), .finished(b_fin), .overflow(b_ovf)
  );

`ifndef CRONO_SPLIT_EN
  assign a_spl = 1'b0;
  assign b_spl = 1'b0;
`endif

  function automatic out_t mk(int t, int mode, bit ovf, bit spl);
    out_t o;
    o.cs  = t % 100;
    o.sec = (t / 100) % 60;
    o.mn  = t / 6000;
    o.run = (mode == 1);
    o.fin = (mode == 2);
    o.ovf = ovf;
    o.spl = spl;
    return o;
  endfunction

  function automatic out_t cur_a();
    out_t o;
    o.cs = int'(a_cs); o.sec = int'(a_sec); o.mn = int'(a_min);
    o.run = a_run; o.fin = a_fin; o.ovf = a_ovf; o.spl = a_spl;
    return o;
  endfunction

  function automatic out_t cur_b();
    out_t o;
    o.cs = int'(b_cs); o.sec = int'(b_sec); o.mn = int'(b_min);
    o.run = b_run; o.fin = b_fin; o.ovf = b_ovf; o.spl = b_spl;
    return o;
  endfunction

  function automatic bit same(out_t x, out_t y);
    return (x.cs == y.cs) && (x.sec == y.sec) && (x.mn == y.mn) && (x.run == y.run) &&
           (x.fin == y.fin) && (x.ovf == y.ovf) && (x.spl == y.spl);
  endfunction

  task automatic cmp(string nm, out_t act, out_t exp);
    nvec++;
    if (!same(act, exp)) begin
      nfail++;
      $display("FAIL %s t=%0t: got %0d:%0d.%0d run=%0b fin=%0b ovf=%0b spl=%0b, expected %0d:%0d.%0d run=%0b fin=%0b ovf=%0b spl=%0b",
               nm, $time, act.mn, act.sec, act.cs, act.run, act.fin, act.ovf, act.spl,
               exp.mn, exp.sec, exp.cs, exp.run, exp.fin, exp.ovf, exp.spl);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: state per instance, time as ticks since start event
  out_t qa[$];
  out_t qb[$];
  int   ecount = 0;
  bit [3:0] hs = '0, hf = '0, hc = '0, hp = '0;
  int   mode[2], s_e[2], frz[2], hold[2];
  bit   ovf[2], sp[2];
  int   div[2] = '{10, 2};

  initial begin
    for (int d = 0; d < 2; d++) begin
      mode[d] = 0; s_e[d] = 0; frz[d] = 0; hold[d] = 0; ovf[d] = 0; sp[d] = 0;
    end
  end

  always @(posedge clk) begin : model
    int t, tp, shown;
    bit ev_s, ev_f, ev_p, clr;
    out_t e;
    if (rst) begin
      hs = '0; hf = '0; hc = '0; hp = '0;
      for (int d = 0; d < 2; d++) begin
        mode[d] = 0; frz[d] = 0; ovf[d] = 0; sp[d] = 0;
      end
    end else begin
      ecount++;
      hs = {hs[2:0], start_sensor};
      hf = {hf[2:0], finish_sensor};
      hc = {hc[2:0], btn_clear};
      hp = {hp[2:0], split_btn};
      // pin sampled two edges ago is the synchronized level; three ago is prev
      ev_s = hs[2] & ~hs[3];
      ev_f = hf[2] & ~hf[3];
      ev_p = hp[2] & ~hp[3];
      clr  = hc[2];
      for (int d = 0; d < 2; d++) begin
        if (clr) begin
          mode[d] = 0; ovf[d] = 0; sp[d] = 0; frz[d] = 0;
        end else if (mode[d] == 0) begin
          if (ev_s) begin
            mode[d] = 1; s_e[d] = ecount;
          end
        end else if (mode[d] == 1) begin
          t  = (ecount - s_e[d]) / div[d];
          tp = (ecount - 1 - s_e[d]) / div[d];
          if (t > LIM) begin
            mode[d] = 2; frz[d] = LIM; ovf[d] = 1; sp[d] = 0;
          end else if (ev_f) begin
            mode[d] = 2; frz[d] = t; sp[d] = 0;
          end else if (ev_p) begin
            if (!sp[d]) hold[d] = tp;
            sp[d] = !sp[d];
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (mode[d] == 0)      shown = 0;
      else if (mode[d] == 2) shown = frz[d];
      else if (sp[d])        shown = hold[d];
      else                   shown = (ecount - s_e[d]) / div[d];
      e = mk(shown, mode[d], ovf[d], sp[d]);
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  end

  // Monitor: compare every edge, 1 time unit after it
  initial begin : monitor
    out_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() == 0 || qb.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL scoreboard_empty t=%0t: got 0 entries, expected 1", $time);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        cmp("dut_a", cur_a(), ea);
        cmp("dut_b", cur_b(), eb);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    btn_clear = 1'b1; idle(3); btn_clear = 1'b0; idle(4);
  endtask

  initial begin : stim
    rst = 1'b1; idle(3); rst = 1'b0; idle(3);

    // finish pulses in IDLE are ignored
    finish_sensor = 1'b1; idle(4); finish_sensor = 1'b0; idle(4);
    finish_sensor = 1'b1; idle(2); finish_sensor = 1'b0; idle(6);
    chk("idle_finish_run", int'(a_run), 0);
    chk("idle_finish_cs", int'(a_cs), 0);

    // start latency, first tick and finish coinciding with a tick
    start_sensor = 1'b1;
    repeat (2) @(posedge clk); #1 chk("run_edge2", int'(a_run), 0);
    @(posedge clk); #1 chk("run_edge3", int'(a_run), 1);
    repeat (9) @(posedge clk); #1 chk("cs_edge12", int'(a_cs), 0);
    @(posedge clk); #1 chk("cs_edge13", int'(a_cs), 1);
    repeat (37) @(posedge clk);
    @(negedge clk) finish_sensor = 1'b1;
    repeat (2) @(posedge clk); #1 chk("fin_edge52", int'(a_fin), 0);
    @(posedge clk); #1 chk("fin_edge53", int'(a_fin), 1);
    chk("frozen_cs_53", int'(a_cs), 5);
    idle(5); start_sensor = 1'b0; finish_sensor = 1'b0; idle(30);
    chk("frozen_cs_later", int'(a_cs), 5);

    // clear in FINISHED
    do_clear();
    chk("clear_fin", int'(a_fin), 0);
    chk("clear_cs", int'(a_cs), 0);

    // clear held across a start edge
    btn_clear = 1'b1; idle(3); start_sensor = 1'b1; idle(6); start_sensor = 1'b0; idle(2);
    btn_clear = 1'b0; idle(5);
    chk("clear_beats_start", int'(a_run), 0);

    // start and finish together in IDLE
    start_sensor = 1'b1; finish_sensor = 1'b1; idle(5);
    chk("start_finish_run", int'(a_run), 1);
    chk("start_finish_fin", int'(a_fin), 0);
    start_sensor = 1'b0; finish_sensor = 1'b0; idle(20);
    finish_sensor = 1'b1; idle(5); finish_sensor = 1'b0;
    chk("late_finish", int'(a_fin), 1);
    do_clear();

    // asynchronous reset mid-run
    start_sensor = 1'b1; idle(40); start_sensor = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_cs", int'(a_cs), 0);
    chk("rst_async_run", int'(a_run), 0);
    chk("rst_async_bcs", int'(b_cs), 0);
    idle(3); rst = 1'b0; idle(5);

    // randomized event storms
    for (int r = 0; r < 3; r++) begin
      repeat (300) begin
        @(negedge clk);
        if ($urandom_range(0, 15) == 0) start_sensor = ~start_sensor;
        if ($urandom_range(0, 25) == 0) finish_sensor = ~finish_sensor;
        btn_clear = ($urandom_range(0, 99) < 2);
`ifdef CRONO_SPLIT_EN
        if ($urandom_range(0, 12) == 0) split_btn = ~split_btn;
`endif
      end
      start_sensor = 1'b0; finish_sensor = 1'b0; split_btn = 1'b0;
      do_clear();
    end

`ifdef CRONO_SPLIT_EN
    // split hold while counting continues
    start_sensor = 1'b1;
    repeat (303) @(posedge clk);
    @(negedge clk) split_btn = 1'b1;
    idle(3); split_btn = 1'b0;
    repeat (503) @(posedge clk); #1;
    chk("split_hold_cs", int'(a_cs), 30);
    chk("split_active", int'(a_spl), 1);
    @(negedge clk) split_btn = 1'b1;
    idle(4); split_btn = 1'b0;
    chk("split_release", int'(a_spl), 0);
    chk("split_live_cs", int'(a_cs >= 7'd80), 1);
    start_sensor = 1'b0;
    do_clear();
`endif

    // rollover 0:59.99 -> 1:00.00 then saturation at 1:59.99 (dut_b)
    start_sensor = 1'b1;
    repeat (12002) @(posedge clk); #1;
    chk("roll_pre_min", int'(b_min), 0);
    chk("roll_pre_sec", int'(b_sec), 59);
    chk("roll_pre_cs", int'(b_cs), 99);
    @(posedge clk); #1;
    chk("roll_min", int'(b_min), 1);
    chk("roll_sec", int'(b_sec), 0);
    chk("roll_cs", int'(b_cs), 0);
    idle(12100);
    start_sensor = 1'b0;
    chk("sat_ovf", int'(b_ovf), 1);
    chk("sat_fin", int'(b_fin), 1);
    chk("sat_time", int'(b_min) * 10000 + int'(b_sec) * 100 + int'(b_cs), 15999);
    do_clear();
    chk("clear_ovf", int'(b_ovf), 0);
    chk("clear_idle", int'(b_run) + int'(b_fin), 0);

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
